// File: rtl/alu_pipe_pkg.sv
// Shared opcode encoding and helpers for the pipelined DSP execution unit.
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_PASSC = 4'd5,
        OP_SLT   = 4'd6,
        OP_MUL   = 4'd7,
        OP_MACZ  = 4'd8,
        OP_MAC   = 4'd9
    } op_t;

    function automatic logic is_mac(input logic [3:0] op);
        return (op == OP_MACZ) || (op == OP_MAC);
    endfunction

    function automatic logic is_known_op(input logic [3:0] op);
        return op <= OP_MAC;
    endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// Register slice with valid bit; holds while en is low, clears on async reset.
module alu_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         vld_d,
    input  logic [W-1:0] d,
    output logic         vld_q,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            q     <= '0;
        end else if (en) begin
            vld_q <= vld_d;
            q     <= d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU/MAC execution unit with selectable depth (1..3), global stall
// and operand-A loopback from the result register.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MUL_W  = 18,
    parameter int PIPE   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] c_i,
    input  logic              fwd_i,
    input  logic              stall_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] p_o,
    output logic              zero_o,
    output logic              neg_o,
    output logic              ovf_o
);

    localparam int M = DATA_W - 1;

    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
    } opnd_t;

    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] prod;
        logic              ovf;
    } mid_t;

    function automatic mid_t compute(input opnd_t x);
        mid_t m;
        logic signed [DATA_W-1:0] ma, mb;
        // Sign-extended operands make a DATA_W-wide multiply yield the low bits directly
        ma     = DATA_W'($signed(x.a[MUL_W-1:0]));
        mb     = DATA_W'($signed(x.b[MUL_W-1:0]));
        m.op   = x.op;
        m.prod = ma * mb;
        m.ovf  = 1'b0;
        m.res  = '0;
        case (x.op)
            OP_ADD: begin
                m.res = x.a + x.b;
                m.ovf = (x.a[M] == x.b[M]) && (m.res[M] != x.a[M]);
            end
            OP_SUB: begin
                m.res = x.a - x.b;
                m.ovf = (x.a[M] != x.b[M]) && (m.res[M] != x.a[M]);
            end
            OP_AND:          m.res = x.a & x.b;
            OP_OR:           m.res = x.a | x.b;
            OP_XOR:          m.res = x.a ^ x.b;
            OP_PASSC:        m.res = x.c;
            OP_SLT:          m.res = {{(DATA_W-1){1'b0}}, $signed(x.a) < $signed(x.b)};
            OP_MUL, OP_MACZ: m.res = m.prod;
            default:         m.res = '0;
        endcase
        return m;
    endfunction

    logic [DATA_W-1:0] acc;
    opnd_t             iss;
    mid_t              mid_q;
    logic              mid_vld;

    always_comb begin
        iss.op = op_i;
        iss.a  = fwd_i ? p_o : a_i;
        iss.b  = b_i;
        iss.c  = c_i;
    end

    generate
        if (PIPE >= 3) begin : g_s1
            opnd_t s1_q;
            mid_t  s2_d;
            logic  s1_vld;
            alu_pipe_stage #(.W($bits(opnd_t))) u_s1 (
                .clk(clk), .rst(rst), .en(~stall_i),
                .vld_d(valid_i), .d(iss), .vld_q(s1_vld), .q(s1_q)
            );
            assign s2_d = compute(s1_q);
            alu_pipe_stage #(.W($bits(mid_t))) u_s2 (
                .clk(clk), .rst(rst), .en(~stall_i),
                .vld_d(s1_vld), .d(s2_d), .vld_q(mid_vld), .q(mid_q)
            );
        end else if (PIPE == 2) begin : g_s2
            mid_t s2_d;
            assign s2_d = compute(iss);
            alu_pipe_stage #(.W($bits(mid_t))) u_s2 (
                .clk(clk), .rst(rst), .en(~stall_i),
                .vld_d(valid_i), .d(s2_d), .vld_q(mid_vld), .q(mid_q)
            );
        end else begin : g_comb
            assign mid_vld = valid_i;
            assign mid_q   = compute(iss);
        end
    endgenerate

    // Final stage: the MAC add reads acc here so back-to-back MACs chain in order
    logic [DATA_W-1:0] fin_p;
    logic              fin_ovf, fin_known;

    always_comb begin
        fin_known = is_known_op(mid_q.op);
        fin_p     = mid_q.res;
        fin_ovf   = mid_q.ovf;
        if (mid_q.op == OP_MAC) begin
            fin_p   = acc + mid_q.prod;
            fin_ovf = (acc[M] == mid_q.prod[M]) && (fin_p[M] != acc[M]);
        end
        if (!fin_known) begin
            fin_p   = '0;
            fin_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= 1'b0;
            p_o     <= '0;
            zero_o  <= 1'b0;
            neg_o   <= 1'b0;
            ovf_o   <= 1'b0;
            acc     <= '0;
        end else if (!stall_i) begin
            valid_o <= mid_vld;
            if (mid_vld) begin
                p_o    <= fin_p;
                zero_o <= fin_known && (fin_p == '0);
                neg_o  <= fin_p[M];
                ovf_o  <= fin_ovf;
                if (is_mac(mid_q.op))
                    acc <= fin_p;
            end
        end
    end

endmodule
